nn_layer_scheduler: RTL and testbench

- Sequencer for a single shared multiply-accumulate datapath that replaces three parallel fully-connected layer instances.
- Walks the MNIST network FC1 (784→16), FC2 (16→16) and FC3 (16→10) neuron by neuron.
- Generates weight, activation and bias addresses plus MAC control strobes; raises done when all 10 output scores are written.
- Sits between the inference top level and the shared MAC, weight ROMs and activation buffers.

---
 rtl/nn_layer_scheduler.sv | 114 +++++++++++
 tb/tb_nn_layer_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/nn_layer_scheduler.sv
// nn_layer_scheduler: sequences FC1/FC2/FC3 neuron by neuron through one shared MAC datapath
module nn_layer_scheduler #(
    parameter int IN1     = 784,
    parameter int N1      = 16,
    parameter int N2      = 16,
    parameter int N3      = 10,
    parameter int MAC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic        busy,
    output logic        done,
    output logic [1:0]  layer_sel,
    output logic [13:0] w_addr,
    output logic [9:0]  x_addr,
    output logic [3:0]  b_addr,
    output logic        mac_clr,
    output logic        mac_en,
    output logic        bias_en,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic        relu_en
);
    typedef enum logic [2:0] {IDLE, CLR, MAC, BIAS, DRAIN, WRITE, DONE} state_t;
    localparam int DW = $clog2(MAC_LAT + 1);
    state_t state, state_nx;
    logic [1:0] layer, layer_nx;
    logic [3:0] n, n_nx;
    logic [9:0] k, k_nx;
    logic [13:0] wk, wk_nx;
    logic [DW-1:0] d, d_nx;
    logic [9:0] k_last;
    logic [3:0] n_last;
    logic run;
    always_comb begin
        k_last   = layer == 2'd0 ? 10'(IN1 - 1) : layer == 2'd1 ? 10'(N1 - 1) : 10'(N2 - 1);
        n_last   = layer == 2'd0 ? 4'(N1 - 1) : layer == 2'd1 ? 4'(N2 - 1) : 4'(N3 - 1);
        run      = !stall || state == IDLE || state == DONE;
        state_nx = state;
        layer_nx = layer;
        n_nx     = n;
        k_nx     = k;
        wk_nx    = wk;
        d_nx     = d;
        if (run) begin
            case (state)
                IDLE: if (start) begin
                    state_nx = CLR;
                    layer_nx = '0;
                    n_nx     = '0;
                    k_nx     = '0;
                    wk_nx    = '0;
                end
                CLR:  state_nx = MAC;
                MAC: if (k == k_last) state_nx = BIAS;
                     else begin
                         k_nx  = k + 10'd1;
                         wk_nx = wk + 14'd1;
                     end
                BIAS: state_nx = DRAIN;
                DRAIN: if (d == DW'(MAC_LAT - 1)) begin
                    state_nx = WRITE;
                    d_nx     = '0;
                end else d_nx = d + 1'b1;
                // weights of one layer are contiguous, so wk just keeps counting across neurons
                WRITE: begin
                    state_nx = CLR;
                    k_nx     = '0;
                    if (n != n_last) begin
                        n_nx  = n + 4'd1;
                        wk_nx = wk + 14'd1;
                    end else if (layer != 2'd2) begin
                        layer_nx = layer + 2'd1;
                        n_nx     = '0;
                        wk_nx    = '0;
                    end else state_nx = DONE;
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            layer <= '0;
            n     <= '0;
            k     <= '0;
            wk    <= '0;
            d     <= '0;
        end else begin
            state <= state_nx;
            layer <= layer_nx;
            n     <= n_nx;
            k     <= k_nx;
            wk    <= wk_nx;
            d     <= d_nx;
        end
    end
    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;
    assign layer_sel = layer;
    assign w_addr    = wk;
    assign x_addr    = k;
    assign b_addr    = n;
    assign wb_addr   = n;
    assign mac_clr   = state == CLR && !stall;
    assign mac_en    = state == MAC && !stall;
    assign bias_en   = state == BIAS && !stall;
    assign wb_en     = state == WRITE && !stall;
    assign relu_en   = wb_en && layer != 2'd2;
endmodule

// File: tb/tb_nn_layer_scheduler.sv
// tb_nn_layer_scheduler: random-stimulus scoreboard bench for nn_layer_scheduler
module tb_nn_layer_scheduler;
    logic clk = 0, rst = 1, start = 0, stall = 0;
    logic busy, done, mac_clr, mac_en, bias_en, wb_en, relu_en;
    logic [1:0] layer_sel;
    logic [13:0] w_addr;
    logic [9:0] x_addr;
    logic [3:0] b_addr, wb_addr;

    nn_layer_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy), .done(done),
        .layer_sel(layer_sel), .w_addr(w_addr), .x_addr(x_addr), .b_addr(b_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .bias_en(bias_en), .wb_en(wb_en),
        .wb_addr(wb_addr), .relu_en(relu_en)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  kind;
        logic [1:0]  layer;
        logic [13:0] w;
        logic [9:0]  x;
        logic [3:0]  n;
        logic        relu;
    } ev_t;
    ev_t q[$];
    ev_t a, e;
    int checks = 0, failures = 0;
    bit mon_on = 0;
    int exp_done = -1, done_seen = 0, t0 = 0, s_cnt;
    int n_clr, n_mac, n_bias, n_wb;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // expected strobe stream: one event per strobe cycle, straight from the layer/neuron/operand walk
    function automatic void build();
        int kk[3] = '{784, 16, 16};
        int nn[3] = '{16, 16, 10};
        ev_t v;
        q.delete();
        for (int l = 0; l < 3; l++)
            for (int j = 0; j < nn[l]; j++) begin
                v = '0; v.layer = 2'(l); v.kind = 3'd1; q.push_back(v);
                for (int i = 0; i < kk[l]; i++) begin
                    v = '0; v.layer = 2'(l); v.kind = 3'd2;
                    v.w = 14'(j * kk[l] + i); v.x = 10'(i); q.push_back(v);
                end
                v = '0; v.layer = 2'(l); v.kind = 3'd3; v.n = 4'(j); q.push_back(v);
                v = '0; v.layer = 2'(l); v.kind = 3'd4; v.n = 4'(j); v.relu = (l != 2); q.push_back(v);
            end
    endfunction

    function automatic ev_t mask(input ev_t v, input logic [2:0] kind);
        ev_t m = v;
        if (kind != 3'd2) begin m.w = '0; m.x = '0; end
        if (kind < 3'd3) m.n = '0;
        if (kind != 3'd4) m.relu = 1'b0;
        return m;
    endfunction

    always @(negedge clk) if (mon_on) begin
        s_cnt = int'(mac_clr) + int'(mac_en) + int'(bias_en) + int'(wb_en);
        n_clr  += int'(mac_clr);
        n_mac  += int'(mac_en);
        n_bias += int'(bias_en);
        n_wb   += int'(wb_en);
        if (s_cnt > 1) chk("one_strobe", s_cnt, 1);
        if (stall) chk("stall_quiet", s_cnt, 0);
        if (s_cnt > 0) begin
            a.kind  = mac_clr ? 3'd1 : mac_en ? 3'd2 : bias_en ? 3'd3 : 3'd4;
            a.layer = layer_sel;
            a.w     = w_addr;
            a.x     = x_addr;
            a.n     = bias_en ? b_addr : wb_addr;
            a.relu  = relu_en;
            if (q.size() == 0) chk("unexpected_event", a.kind, 0);
            else begin
                e = q.pop_front();
                checks++;
                if (mask(a, e.kind) != mask(e, e.kind)) begin
                    failures++;
                    $display("FAIL event cyc=%0d got k=%0d l=%0d w=%0d x=%0d n=%0d r=%0d exp k=%0d l=%0d w=%0d x=%0d n=%0d r=%0d",
                        cyc, a.kind, a.layer, a.w, a.x, a.n, a.relu, e.kind, e.layer, e.w, e.x, e.n, e.relu);
                end
            end
        end
        if (done) begin
            done_seen++;
            chk("done_cycle", cyc, exp_done);
        end
    end

    function automatic longint outs();
        return {busy, done, layer_sel, w_addr, x_addr, b_addr, mac_clr, mac_en, bias_en, wb_en, wb_addr, relu_en};
    endfunction

    // mode 0: clean run, 1: 5-cycle stall at k=100, 2: random stall/start, 3: reset at cycle 500
    task automatic run(input int mode);
        int unst = 0, stl = 0;
        bit s;
        build();
        exp_done = -1; done_seen = 0;
        n_clr = 0; n_mac = 0; n_bias = 0; n_wb = 0;
        @(posedge clk); #2;
        start = 1; mon_on = 1; t0 = cyc;
        chk("busy_c0", busy, 0);
        for (int c = 1; c < 40000; c++) begin
            @(posedge clk); #2;
            s = mode == 1 ? (c >= 102 && c <= 106) : mode == 2 ? (unst < 13170 && $urandom_range(3) == 0) : 1'b0;
            stall = s;
            start = mode == 0 ? (c == 13171 || c == 60) :
                    mode == 2 ? ((exp_done < 0 || cyc <= exp_done) && $urandom_range(1) == 1) : (c == 50);
            if (unst < 13170) begin
                if (s) stl++; else unst++;
                if (unst == 13170) exp_done = t0 + 13171 + stl;
            end
            #1;
            if (c == 1) chk("busy_rise", busy, 1);
            if (mode == 1 && s) begin
                chk("frozen_w", w_addr, 100);
                chk("frozen_x", x_addr, 100);
            end
            if (mode == 3 && c == 500) begin
                rst = 1; #1;
                mon_on = 0;
                chk("abort_zero", outs(), 0);
                break;
            end
            if (exp_done >= 0 && cyc == exp_done + 2) begin
                chk("idle_after_done", busy, 0);
                break;
            end
        end
        stall = 0; start = 0; mon_on = 0;
        if (mode != 3) begin
            chk("done_once", done_seen, 1);
            chk("queue_empty", q.size(), 0);
        end
        if (mode == 1) chk("stall_done_delay", exp_done - t0, 13176);
        if (mode == 0) begin
            chk("tot_mac", n_mac, 12960);
            chk("tot_bias", n_bias, 42);
            chk("tot_wb", n_wb, 42);
            chk("tot_clr", n_clr, 42);
        end
    endtask

    task automatic reset_idle(input int n);
        rst = 1;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #3;
            chk("idle_zero", outs(), 0);
        end
    endtask

    initial begin
        reset_idle(20);
        run(0);
        run(1);
        run(2);
        run(3);
        reset_idle(10);
        run(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
